// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the core's icache/dcache requesters, the arbiter
// and the shared downstream memory port.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              i_req_valid;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ready;
   logic              i_data_valid;
   logic [DATA_W-1:0] i_data;

   logic              d_req_valid;
   logic              d_wen;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [1:0]        d_wlen;
   logic              d_ready;
   logic              d_data_valid;
   logic [DATA_W-1:0] d_data;

   logic              flush;

   logic              mem_req_valid;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [1:0]        mem_wlen;
   logic              mem_ready;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_rdata;

   logic              grant;
   logic              busy;
   logic              err;

   // Arbiter view.
   modport slave (
      input  i_req_valid, i_addr, d_req_valid, d_wen, d_addr, d_wdata, d_wlen,
             flush, mem_ready, mem_resp_valid, mem_rdata,
      output i_ready, i_data_valid, i_data, d_ready, d_data_valid, d_data,
             mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wlen,
             grant, busy, err
   );

   // Environment view: core requesters plus downstream memory.
   modport master (
      output i_req_valid, i_addr, d_req_valid, d_wen, d_addr, d_wdata, d_wlen,
             flush, mem_ready, mem_resp_valid, mem_rdata,
      input  i_ready, i_data_valid, i_data, d_ready, d_data_valid, d_data,
             mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wlen,
             grant, busy, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one transaction at a time, dcache priority with a
// bounded starvation guard for fetch, and fetch-abort on pipeline flush.
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t            state_reg;
   logic [3:0]        streak_reg;
   logic              drop_reg;
   logic              grant_reg;
   logic              busy_reg;
   logic              err_reg;
   logic              mem_req_valid_reg;
   logic              mem_wen_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic [1:0]        mem_wlen_reg;
   logic              i_data_valid_reg;
   logic [DATA_W-1:0] i_data_reg;
   logic              d_data_valid_reg;
   logic [DATA_W-1:0] d_data_reg;

   logic starved;
   logic win_d;
   logic win_i;
   logic fetch_flush;

   assign starved     = (streak_reg == LIMIT) && bus.i_req_valid;
   assign win_d       = bus.d_req_valid && !starved;
   assign win_i       = bus.i_req_valid && !win_d;
   assign fetch_flush = bus.flush && !grant_reg;

   // Readies are gated by reset so every output reads 0 while rst is low.
   assign bus.d_ready = rst && (state_reg == IDLE) && win_d;
   assign bus.i_ready = rst && (state_reg == IDLE) && win_i;

   assign bus.mem_req_valid = mem_req_valid_reg;
   assign bus.mem_wen       = mem_wen_reg;
   assign bus.mem_addr      = mem_addr_reg;
   assign bus.mem_wdata     = mem_wdata_reg;
   assign bus.mem_wlen      = mem_wlen_reg;
   assign bus.i_data_valid  = i_data_valid_reg;
   assign bus.i_data        = i_data_reg;
   assign bus.d_data_valid  = d_data_valid_reg;
   assign bus.d_data        = d_data_reg;
   assign bus.grant         = grant_reg;
   assign bus.busy          = busy_reg;
   assign bus.err           = err_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg         <= IDLE;
         streak_reg        <= '0;
         drop_reg          <= 1'b0;
         grant_reg         <= 1'b0;
         busy_reg          <= 1'b0;
         err_reg           <= 1'b0;
         mem_req_valid_reg <= 1'b0;
         mem_wen_reg       <= 1'b0;
         mem_addr_reg      <= '0;
         mem_wdata_reg     <= '0;
         mem_wlen_reg      <= '0;
         i_data_valid_reg  <= 1'b0;
         i_data_reg        <= '0;
         d_data_valid_reg  <= 1'b0;
         d_data_reg        <= '0;
      end else begin
         i_data_valid_reg <= 1'b0;
         d_data_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               drop_reg <= 1'b0;
               if (bus.mem_resp_valid)
                  err_reg <= 1'b1;
               if (win_d || win_i) begin
                  grant_reg         <= win_d;
                  busy_reg          <= 1'b1;
                  mem_req_valid_reg <= 1'b1;
                  mem_wen_reg       <= win_d && bus.d_wen;
                  mem_addr_reg      <= win_d ? bus.d_addr : bus.i_addr;
                  mem_wdata_reg     <= win_d ? bus.d_wdata : '0;
                  mem_wlen_reg      <= win_d ? bus.d_wlen : 2'd0;
                  // Streak counts dcache grants that made a waiting fetch wait longer.
                  if (win_d && bus.i_req_valid)
                     streak_reg <= (streak_reg == LIMIT) ? LIMIT : streak_reg + 4'd1;
                  else
                     streak_reg <= '0;
                  state_reg <= REQ;
               end
            end
            REQ: begin
               if (bus.mem_resp_valid)
                  err_reg <= 1'b1;
               if (fetch_flush)
                  drop_reg <= 1'b1;
               if (bus.mem_ready) begin
                  mem_req_valid_reg <= 1'b0;
                  state_reg         <= WAIT;
               end
            end
            WAIT: begin
               if (fetch_flush)
                  drop_reg <= 1'b1;
               if (bus.mem_resp_valid) begin
                  if (grant_reg) begin
                     d_data_reg       <= mem_wen_reg ? '0 : bus.mem_rdata;
                     d_data_valid_reg <= 1'b1;
                  end else if (!(drop_reg || bus.flush)) begin
                     i_data_reg       <= bus.mem_rdata;
                     i_data_valid_reg <= 1'b1;
                  end
                  busy_reg  <= 1'b0;
                  drop_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter plus hand sequences for
// starvation rotation and asynchronous reset.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        ir;  logic [31:0] ia;
      logic        dr;  logic        dw;  logic [31:0] da; logic [63:0] dwd; logic [1:0] dl;
      logic        fl;  logic        mr;  logic        mv; logic [63:0] rd;
      logic        eir; logic        edr; logic        emq; logic emw; logic [1:0] eml;
      logic [31:0] ema; logic        eg;  logic        eb;
      logic        eiv; logic [63:0] eid; logic        edv; logic [63:0] edd; logic eer;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [63:0] dwd, input logic [1:0] dl,
                      input logic fl, input logic mr, input logic mv, input logic [63:0] rd,
                      input logic eir, input logic edr, input logic emq, input logic emw,
                      input logic [1:0] eml, input logic [31:0] ema, input logic eg,
                      input logic eb, input logic eiv, input logic [63:0] eid,
                      input logic edv, input logic [63:0] edd, input logic eer);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.dl = dl;
      v.fl = fl; v.mr = mr; v.mv = mv; v.rd = rd;
      v.eir = eir; v.edr = edr; v.emq = emq; v.emw = emw; v.eml = eml; v.ema = ema;
      v.eg = eg; v.eb = eb; v.eiv = eiv; v.eid = eid; v.edv = edv; v.edd = edd; v.eer = eer;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.i_req_valid = 0; bus.i_addr = '0; bus.d_req_valid = 0; bus.d_wen = 0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.d_wlen = '0; bus.flush = 0;
      bus.mem_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;
   endtask

   localparam logic [31:0] A0 = 32'h8000_0000;
   localparam logic [31:0] A1 = 32'h8000_0040;
   localparam logic [31:0] A2 = 32'h8000_0080;
   localparam logic [31:0] A3 = 32'h8000_00C0;
   localparam logic [31:0] A4 = 32'h8000_0100;

   initial begin
      vec_t v;
      logic exp_d;
      drive_idle();

      //  ir ia  dr dw da      dwd           dl fl mr mv rd         eir edr emq emw eml ema     eg eb eiv eid     edv edd     eer
      // single fetch
      add(1, A0, 0, 0, 0,      0,            0, 0, 0, 0, 0,         1,  0,  0,  0,  0,  0,      0, 0, 0,  0,      0,  0,      0);
      add(0, A0, 0, 0, 0,      0,            0, 0, 1, 0, 0,         0,  0,  1,  0,  0,  A0,     0, 1, 0,  0,      0,  0,      0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 1, 'h13,      0,  0,  0,  0,  0,  0,      0, 1, 0,  0,      0,  0,      0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 0, 0,         0,  0,  0,  0,  0,  0,      0, 0, 1,  'h13,   0,  0,      0);
      // write with one-cycle memory stall
      add(0, 0,  1, 1, 'h100,  'hDEADBEEF,   2, 0, 0, 0, 0,         0,  1,  0,  0,  0,  0,      0, 0, 0,  'h13,   0,  0,      0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 0, 0,         0,  0,  1,  1,  2,  'h100,  1, 1, 0,  'h13,   0,  0,      0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 1, 0, 0,         0,  0,  1,  1,  2,  'h100,  1, 1, 0,  'h13,   0,  0,      0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 1, 'hFFFF,    0,  0,  0,  0,  0,  0,      1, 1, 0,  'h13,   0,  0,      0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 0, 0,         0,  0,  0,  0,  0,  0,      0, 0, 0,  'h13,   1,  0,      0);
      // simultaneous requests: dcache read first, fetch at the next IDLE
      add(1, A1, 1, 0, 'h200,  0,            0, 0, 0, 0, 0,         0,  1,  0,  0,  0,  0,      0, 0, 0,  'h13,   0,  0,      0);
      add(1, A1, 0, 0, 0,      0,            0, 0, 1, 0, 0,         0,  0,  1,  0,  0,  'h200,  1, 1, 0,  'h13,   0,  0,      0);
      add(1, A1, 0, 0, 0,      0,            0, 0, 0, 1, 'hAB,      0,  0,  0,  0,  0,  0,      1, 1, 0,  'h13,   0,  0,      0);
      add(1, A1, 0, 0, 0,      0,            0, 0, 0, 0, 0,         1,  0,  0,  0,  0,  0,      0, 0, 0,  'h13,   1,  'hAB,   0);
      add(0, A1, 0, 0, 0,      0,            0, 0, 1, 0, 0,         0,  0,  1,  0,  0,  A1,     0, 1, 0,  'h13,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 1, 'h55,      0,  0,  0,  0,  0,  0,      0, 1, 0,  'h13,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 0, 0,         0,  0,  0,  0,  0,  0,      0, 0, 1,  'h55,   0,  'hAB,   0);
      // flush during WAIT drops the fetch response
      add(1, A2, 0, 0, 0,      0,            0, 0, 0, 0, 0,         1,  0,  0,  0,  0,  0,      0, 0, 0,  'h55,   0,  'hAB,   0);
      add(0, A2, 0, 0, 0,      0,            0, 0, 1, 0, 0,         0,  0,  1,  0,  0,  A2,     0, 1, 0,  'h55,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 1, 0, 0, 0,         0,  0,  0,  0,  0,  0,      0, 1, 0,  'h55,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 1, 'h1234,    0,  0,  0,  0,  0,  0,      0, 1, 0,  'h55,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 0, 0,         0,  0,  0,  0,  0,  0,      0, 0, 0,  'h55,   0,  'hAB,   0);
      // flush coinciding with the response
      add(1, A3, 0, 0, 0,      0,            0, 0, 0, 0, 0,         1,  0,  0,  0,  0,  0,      0, 0, 0,  'h55,   0,  'hAB,   0);
      add(0, A3, 0, 0, 0,      0,            0, 0, 1, 0, 0,         0,  0,  1,  0,  0,  A3,     0, 1, 0,  'h55,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 1, 0, 1, 'h9999,    0,  0,  0,  0,  0,  0,      0, 1, 0,  'h55,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 0, 0,         0,  0,  0,  0,  0,  0,      0, 0, 0,  'h55,   0,  'hAB,   0);
      // next fetch unaffected
      add(1, A4, 0, 0, 0,      0,            0, 0, 0, 0, 0,         1,  0,  0,  0,  0,  0,      0, 0, 0,  'h55,   0,  'hAB,   0);
      add(0, A4, 0, 0, 0,      0,            0, 0, 1, 0, 0,         0,  0,  1,  0,  0,  A4,     0, 1, 0,  'h55,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 1, 'h77,      0,  0,  0,  0,  0,  0,      0, 1, 0,  'h55,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 0, 0,         0,  0,  0,  0,  0,  0,      0, 0, 1,  'h77,   0,  'hAB,   0);
      // flush in IDLE is harmless; stray response sets sticky err
      add(0, 0,  0, 0, 0,      0,            0, 1, 0, 0, 0,         0,  0,  0,  0,  0,  0,      0, 0, 0,  'h77,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 1, 'h5,       0,  0,  0,  0,  0,  0,      0, 0, 0,  'h77,   0,  'hAB,   0);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 0, 0,         0,  0,  0,  0,  0,  0,      0, 0, 0,  'h77,   0,  'hAB,   1);
      add(0, 0,  0, 0, 0,      0,            0, 0, 0, 0, 0,         0,  0,  0,  0,  0,  0,      0, 0, 0,  'h77,   0,  'hAB,   1);

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset busy", bus.busy, 0);
      chk("reset mem_req_valid", bus.mem_req_valid, 0);
      chk("reset err", bus.err, 0);
      chk("reset i_data", bus.i_data, 0);
      rst = 1'b1;

      for (int n = 0; n < vecs.size(); n++) begin
         @(negedge clk);
         v = vecs[n];
         bus.i_req_valid = v.ir; bus.i_addr = v.ia; bus.d_req_valid = v.dr; bus.d_wen = v.dw;
         bus.d_addr = v.da; bus.d_wdata = v.dwd; bus.d_wlen = v.dl; bus.flush = v.fl;
         bus.mem_ready = v.mr; bus.mem_resp_valid = v.mv; bus.mem_rdata = v.rd;
         #1;
         chk($sformatf("v%0d i_ready", n), bus.i_ready, v.eir);
         chk($sformatf("v%0d d_ready", n), bus.d_ready, v.edr);
         chk($sformatf("v%0d mem_req_valid", n), bus.mem_req_valid, v.emq);
         chk($sformatf("v%0d busy", n), bus.busy, v.eb);
         chk($sformatf("v%0d i_data_valid", n), bus.i_data_valid, v.eiv);
         chk($sformatf("v%0d i_data", n), bus.i_data, v.eid);
         chk($sformatf("v%0d d_data_valid", n), bus.d_data_valid, v.edv);
         chk($sformatf("v%0d d_data", n), bus.d_data, v.edd);
         chk($sformatf("v%0d err", n), bus.err, v.eer);
         if (v.eb)
            chk($sformatf("v%0d grant", n), bus.grant, v.eg);
         if (v.emq) begin
            chk($sformatf("v%0d mem_addr", n), bus.mem_addr, v.ema);
            chk($sformatf("v%0d mem_wen", n), bus.mem_wen, v.emw);
            chk($sformatf("v%0d mem_wlen", n), bus.mem_wlen, v.eml);
         end
         $display("vector %0d applied", n);
      end

      // starvation guard: both sides requesting continuously
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         bus.mem_resp_valid = 0; bus.flush = 0;
         bus.i_req_valid = 1; bus.i_addr = A0; bus.d_req_valid = 1; bus.d_wen = 0;
         bus.d_addr = 'h300;
         exp_d = ((t % 5) != 4);
         #1;
         chk($sformatf("starve%0d d_ready", t), bus.d_ready, exp_d);
         chk($sformatf("starve%0d i_ready", t), bus.i_ready, !exp_d);
         $display("grant %0d -> %s", t, bus.d_ready ? "D" : "I");
         @(negedge clk);
         bus.mem_ready = 1;
         #1;
         chk($sformatf("starve%0d grant", t), bus.grant, exp_d);
         @(negedge clk);
         bus.mem_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 64'(t);
      end
      @(negedge clk);
      drive_idle();
      #1;
      chk("starve last i_data_valid", bus.i_data_valid, 1);
      chk("starve last i_data", bus.i_data, 9);

      // async reset while waiting for a fetch response
      @(negedge clk);
      bus.i_req_valid = 1; bus.i_addr = A0;
      @(negedge clk);
      bus.i_req_valid = 0; bus.mem_ready = 1;
      @(negedge clk);
      bus.mem_ready = 0; bus.i_req_valid = 1; bus.d_req_valid = 1;
      #1;
      chk("pre-reset busy", bus.busy, 1);
      #1 rst = 1'b0;
      #1;
      chk("async busy", bus.busy, 0);
      chk("async mem_req_valid", bus.mem_req_valid, 0);
      chk("async mem_addr", bus.mem_addr, 0);
      chk("async i_ready", bus.i_ready, 0);
      chk("async d_ready", bus.d_ready, 0);
      chk("async i_data", bus.i_data, 0);
      chk("async d_data", bus.d_data, 0);
      chk("async grant", bus.grant, 0);
      chk("async err", bus.err, 0);
      @(negedge clk);
      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("post-reset busy", bus.busy, 0);
      chk("post-reset err", bus.err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one downstream memory/bus port between the instruction-cache requester (PC/IF_ID fetch path) and the data-cache requester (ID/MEM load-store path). It sits between the core's icache/dcache handshake signals and the SoC memory port. It serialises one transaction at a time, gives the data side priority with a bounded starvation guard for fetch, and supports fetch-abort on pipeline flush.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width
- STARVE_LIMIT, 4, max consecutive dcache grants while icache waits (1..15)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req_valid_i  in  1  fetch request; held with i_addr_i until i_ready_o
- i_addr_i  in  ADDR_W  fetch address
- i_ready_o  out  1  combinational; request captured this cycle
- i_data_valid_o  out  1  one-cycle pulse, fetch data valid
- i_data_o  out  DATA_W  fetch data, held until next fetch response
- d_req_valid_i  in  1  data request; fields held until d_ready_o
- d_wen_i  in  1  1 = write
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_wlen_i  in  2  write size (0=B,1=H,2=W,3=D), passed through
- d_ready_o  out  1  combinational; request captured this cycle
- d_data_valid_o  out  1  one-cycle pulse; read data or write ack
- d_data_o  out  DATA_W  read data (0 for writes)
- flush_i  in  1  abort in-flight fetch
- mem_req_valid_o  out  1  downstream request
- mem_wen_o, mem_addr_o, mem_wdata_o, mem_wlen_o  out  1/ADDR_W/DATA_W/2  registered request fields
- mem_ready_i  in  1  downstream accepted request
- mem_resp_valid_i  in  1  downstream response (read data or write ack)
- mem_rdata_i  in  DATA_W  response data
- grant_o  out  1  owner of current transaction (1 = dcache)
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky: response received outside WAIT

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: if any request valid, select winner, capture its fields into mem_* registers, assert winner's ready_o (comb), go to REQ. Never both ready_o in one cycle.
- Selection: dcache wins unless streak == STARVE_LIMIT and i_req_valid_i, then icache wins.
- streak (4-bit): on dcache grant with i_req_valid_i high, +1 (saturates at STARVE_LIMIT); on icache grant or i_req_valid_i low at a grant, cleared.
- REQ: mem_req_valid_o=1, fields stable; on mem_ready_i go to WAIT.
- WAIT: on mem_resp_valid_i register mem_rdata_i into owner's data_o (d_data_o=0 for writes), pulse owner's data_valid_o next cycle, go to IDLE.
- Flush: flush_i while state in REQ/WAIT with grant_o=0 sets drop. Request is not retracted; response is consumed, i_data_valid_o suppressed, i_data_o unchanged. flush_i in IDLE or during dcache transaction: no effect. drop clears on entry to IDLE.
- mem_resp_valid_i in IDLE/REQ: ignored, err_o set until reset.

## Timing
- Reset (rst=0, async): state IDLE, all outputs 0, streak 0, drop 0, err_o 0.
- Deassertion of rst is synchronous to clk.
- Request at cycle 0 (IDLE) -> mem_req_valid_o cycle 1 -> mem_ready_i earliest cycle 1 -> response earliest cycle 2 -> data_valid_o cycle 3. Minimum 3-cycle turnaround.
- The arbiter is in IDLE in the cycle data_valid_o pulses, so a new grant can occur in that cycle (back-to-back rate = 3 cycles/transaction minimum).
- mem_ready_i and mem_resp_valid_i in the same cycle: not supported (response only counted in WAIT; err_o set).
- flush_i in the same cycle as mem_resp_valid_i during a fetch: pulse suppressed.
- Reset mid-transaction: aborts immediately. The downstream port must be reset concurrently.

## Test plan
- Single fetch: i_req addr 0x80000000, mem_ready at cycle 1, resp 0x00000013 at cycle 2 -> i_ready_o cycle 0, i_data_valid_o=1 with i_data_o=0x13 cycle 3, busy_o low cycle 3.
- Simultaneous: both requests at cycle 0 -> d_ready_o=1, i_ready_o=0, grant_o=1. Fetch granted at the next IDLE.
- Starvation: STARVE_LIMIT=4, icache and dcache requesting continuously -> grants D,D,D,D,I,D,D,D,D,I.
- Write: d_wen=1, addr 0x100, wdata 0xDEADBEEF, wlen=2 -> mem_wen_o=1, mem_wlen_o=2 while mem_req_valid_o. On ack, d_data_valid_o pulses with d_data_o=0.
- Flush: flush_i during fetch WAIT, resp 0x1234 -> no i_data_valid_o, i_data_o keeps old value, next fetch unaffected.
- Async reset: rst=0 while in WAIT -> all outputs 0 without a clock edge. Stray mem_resp_valid_i in IDLE -> err_o=1 and held.
